instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage of the 16-bit MIPS-style processor. Drives the address of the combinational instruction memory from an internal program counter, registers each returned 16-bit instruction word with its PC, and presents it to decode over a valid/ready handshake. Supports branch redirect with flush, and a halt state entered on the all-zero instruction word, which is the memory's default for unprogrammed addresses.

## Interface
- ADDR_W, 8, PC / instruction memory address width
- INSTR_W, 16, instruction word width
- RESET_PC, 8'h00, PC value loaded on reset
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_addr  output  ADDR_W  address to instruction memory; equals current PC (combinational from the PC register)
- imem_data  input  INSTR_W  word returned by instruction memory, valid in the same cycle
- instr_out  output  INSTR_W  registered instruction presented to decode
- pc_out  output  ADDR_W  address instr_out was fetched from
- instr_valid  output  1  instr_out/pc_out hold a live instruction
- instr_ready  input  1  decode accepts the instruction this cycle
- branch_taken  input  1  single-cycle redirect request
- branch_target  input  ADDR_W  new PC, sampled when branch_taken=1
- halted  output  1  fetch stopped on a zero word
- fetch_count  output  16  number of completed handshakes, saturating at 16'hFFFF

## Operation
- Clock is clk; reset is synchronous and active-high.
- States: RUN, HALTED. Reset -> RUN. halted=1 exactly in HALTED.
- Transfer: instr_valid && instr_ready at a rising edge. fetch_count += 1, saturating at 16'hFFFF.
- Load condition: state==RUN && (!instr_valid || instr_ready) && !branch_taken.
- On load with imem_data != 0: instr_out<=imem_data, pc_out<=PC, instr_valid<=1, PC<=PC+1 (mod 2^ADDR_W; 8'hFF wraps to 8'h00).
- On load with imem_data == 0: the word is never presented. instr_valid<=0, state<=HALTED, PC unchanged.
- No load and no branch: instr_out, pc_out, instr_valid and PC hold. A transfer without a load clears instr_valid.
- branch_taken=1 has highest priority (after reset):
  - PC<=branch_target, instr_valid<=0 (flush), state<=RUN.
  - A transfer in the same cycle still completes and is counted.
- HALTED: imem_addr stays at the halt address and no loads occur. Exit only via branch_taken or reset.
- While instr_valid && !instr_ready, instr_out and pc_out must stay stable.

## Timing
- Reset values: PC=RESET_PC, imem_addr=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, halted=0, fetch_count=0, state=RUN.
- First instruction: instr_valid=1 one cycle after the first non-reset rising edge. Latency from PC to instr_out is one register stage.
- Throughput: one instruction per cycle while instr_ready=1.
- Branch: target word is presented on the cycle after the redirect edge (one bubble cycle).
- Halt: halted=1 from the edge that sampled the zero word.
- Reset mid-operation overrides everything, including branch and halt, and flushes the pending word.

## Test plan
- Memory 00:485A 01:4A14 02:4DF6 03:4F96 04:0880 05:4E02 06:6180 07:6800 08:8820, 09 and above zero; ready=1 after reset.
  -> (instr,pc) = (485A,00)…(8820,08) on 9 consecutive cycles.
  -> Then halted=1, instr_valid=0, imem_addr=09, fetch_count=9.
- Same program; instr_ready=0 for 2 cycles while (4DF6,02) is valid.
  -> instr_out=4DF6, pc_out=02 held; imem_addr=03; fetch_count unchanged; next transfer is (4F96,03).
- branch_taken=1, target=8'h06, in the cycle (4A14,01) transfers.
  -> (4A14,01) counted; one bubble; next valid is (6180,06); 4DF6 never presented.
- From HALTED at 09: branch_taken=1, target=8'h00.
  -> halted=0 next cycle; (485A,00) valid the following cycle.
- RESET_PC=8'hFE; addresses FE, FF, 00 hold 1111, 2222, 3333.
  -> pc_out sequence FE, FF, 00; no halt.
- Assert reset while (0880,04) is valid and ready=0.
  -> next cycle: instr_valid=0, instr_out=0, pc_out=0, imem_addr=RESET_PC, fetch_count=0, halted=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle.
// master: the fetch stage; slave: the memory/decode/branch side.
interface instruction_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  pc_out;
    logic               instr_valid;
    logic               instr_ready;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               halted;
    logic [15:0]        fetch_count;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr_out,
        output pc_out,
        output instr_valid,
        input  instr_ready,
        input  branch_taken,
        input  branch_target,
        output halted,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr_out,
        input  pc_out,
        input  instr_valid,
        output instr_ready,
        output branch_taken,
        output branch_target,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC drives the combinational instruction memory, the returned
// word is registered with its PC and offered to decode via valid/ready.
// A zero word stops fetching (HALTED); a branch redirects and flushes.
//
// state  | meaning
// RUN    | fetching one word per cycle when the output register is free
// HALTED | zero word seen; PC frozen until branch or reset
module instruction_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    instruction_fetch_if.master bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic               valid_reg;
    logic [15:0]        count_reg;
    logic               transfer;
    logic               load;
    logic               zero_word;

    assign transfer  = valid_reg && bus.instr_ready;
    assign load      = (state == RUN) && (!valid_reg || bus.instr_ready) && !bus.branch_taken;
    assign zero_word = (bus.imem_data == '0);

    assign bus.imem_addr   = pc;
    assign bus.instr_out   = instr_reg;
    assign bus.pc_out      = pc_reg;
    assign bus.instr_valid = valid_reg;
    assign bus.halted      = (state == HALTED);
    assign bus.fetch_count = count_reg;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Next state: branch always resumes fetching, a zero word stops it
    always_comb begin
        state_next = state;
        if (bus.branch_taken)      state_next = RUN;
        else if (load && zero_word) state_next = HALTED;
    end

    // PC, output register and handshake counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            instr_reg <= '0;
            pc_reg    <= '0;
            valid_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            // a transfer coinciding with a branch still counts
            if (transfer && count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
            if (bus.branch_taken) begin
                pc        <= bus.branch_target;
                valid_reg <= 1'b0;
            end else if (load) begin
                if (!zero_word) begin
                    instr_reg <= bus.imem_data;
                    pc_reg    <= pc;
                    valid_reg <= 1'b1;
                    pc        <= pc + ADDR_W'(1);
                end else begin
                    valid_reg <= 1'b0;
                end
            end else if (transfer) begin
                valid_reg <= 1'b0;
            end
        end
    end
endmodule
